// File: rtl/vector_register_file_if.sv
// Port bundle for vector_register_file: ready, read ports and the lane-masked write port.
// No latency of its own; pure wiring.
// No backpressure: the register file only accepts requests while ready_o is high.
//
// Signals:
//   ready_o        - clear sweep finished, requests are honoured
//   rd_en_i        - per-port read request            [READ_PORTS]
//   rd_addr_i      - per-port read address            [READ_PORTS*AW]
//   rd_data_o      - per-port registered read data    [READ_PORTS*LW]
//   rd_valid_o     - per-port: rd_data_o updated      [READ_PORTS]
//   wr_en_i        - write request
//   wr_addr_i      - write address                    [AW]
//   wr_lane_mask_i - per-lane write enable            [LANE_COUNT]
//   wr_data_i      - write data, lane k at [k*REG_WIDTH +: REG_WIDTH]
interface vector_register_file_if #(
    parameter int REG_COUNT  = 32,
    parameter int REG_WIDTH  = 32,
    parameter int LANE_COUNT = 4,
    parameter int READ_PORTS = 2
);
    localparam int AW = $clog2(REG_COUNT);
    localparam int LW = LANE_COUNT * REG_WIDTH;

    logic                       ready_o;
    logic [READ_PORTS-1:0]      rd_en_i;
    logic [READ_PORTS*AW-1:0]   rd_addr_i;
    logic [READ_PORTS*LW-1:0]   rd_data_o;
    logic [READ_PORTS-1:0]      rd_valid_o;
    logic                       wr_en_i;
    logic [AW-1:0]              wr_addr_i;
    logic [LANE_COUNT-1:0]      wr_lane_mask_i;
    logic [LW-1:0]              wr_data_i;

    // Requester side (core pipeline / testbench).
    modport master (
        input  ready_o,
        input  rd_data_o,
        input  rd_valid_o,
        output rd_en_i,
        output rd_addr_i,
        output wr_en_i,
        output wr_addr_i,
        output wr_lane_mask_i,
        output wr_data_i
    );

    // Register file side.
    modport slave (
        output ready_o,
        output rd_data_o,
        output rd_valid_o,
        input  rd_en_i,
        input  rd_addr_i,
        input  wr_en_i,
        input  wr_addr_i,
        input  wr_lane_mask_i,
        input  wr_data_i
    );
endinterface

// File: rtl/vector_register_file.sv
// Lane-parallel GPU register file: READ_PORTS read ports, one lane-masked write port.
// Reads: 1 cycle registered latency; optional same-cycle write bypass; optional zero register.
// No backpressure; after reset a REG_COUNT-cycle clear sweep runs with ready_o low and requests ignored.
//
// Ports:
//   clk_i   - clock, rising edge
//   reset_i - synchronous active-high reset; (re)starts the clear sweep
//   rf      - slave side of vector_register_file_if (read/write ports, ready_o)
module vector_register_file #(
    parameter int REG_COUNT  = 32,
    parameter int REG_WIDTH  = 32,
    parameter int LANE_COUNT = 4,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    vector_register_file_if.slave   rf
);
    localparam int AW = $clog2(REG_COUNT);
    localparam int LW = LANE_COUNT * REG_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                     state;
    logic [AW-1:0]              clear_cnt;
    logic                       ready_q;

    // Storage has no reset so it can map onto block RAM; the clear sweep
    // zeroes it one register per cycle instead.
    logic [LW-1:0]              mem [REG_COUNT];

    logic [LANE_COUNT-1:0]      mem_we;
    logic [AW-1:0]              mem_waddr;
    logic [LW-1:0]              mem_wdata;

    logic                       wr_drop;
    logic                       wr_live;

    logic [READ_PORTS*LW-1:0]   rd_next;
    logic [READ_PORTS*LW-1:0]   rd_data_q;
    logic [READ_PORTS-1:0]      rd_valid_q;

    // ------------------------------------------------------------------
    // Sweep control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= ST_CLEAR;
            clear_cnt <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_cnt <= clear_cnt + AW'(1);
                    if (clear_cnt == AW'(REG_COUNT - 1)) begin
                        state   <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    state   <= ST_READY;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port: the sweep and the user write share one physical port.
    // ------------------------------------------------------------------
    // Writes to register 0 vanish when it is hardwired to zero; the same
    // flag also suppresses bypass from such a write.
    assign wr_drop = (ZERO_REG != 0) && (rf.wr_addr_i == '0);
    assign wr_live = ready_q && rf.wr_en_i && !wr_drop;

    always_comb begin
        mem_we    = '0;
        mem_waddr = clear_cnt;
        mem_wdata = '0;
        if (!reset_i) begin
            if (state == ST_CLEAR) begin
                mem_we = '1;
            end else if (wr_live) begin
                mem_we    = rf.wr_lane_mask_i;
                mem_waddr = rf.wr_addr_i;
                mem_wdata = rf.wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LANE_COUNT; k++) begin
            if (mem_we[k]) begin
                mem[mem_waddr][k*REG_WIDTH +: REG_WIDTH] <= mem_wdata[k*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports: next-data selection with lane-wise bypass and zero reg.
    // ------------------------------------------------------------------
    always_comb begin
        rd_next = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_next[p*LW +: LW] = mem[rf.rd_addr_i[p*AW +: AW]];
            // Forward only the lanes being written; unmasked lanes keep
            // the stored (old) value.
            if ((BYPASS != 0) && wr_live && (rf.wr_addr_i == rf.rd_addr_i[p*AW +: AW])) begin
                for (int k = 0; k < LANE_COUNT; k++) begin
                    if (rf.wr_lane_mask_i[k]) begin
                        rd_next[p*LW + k*REG_WIDTH +: REG_WIDTH] = rf.wr_data_i[k*REG_WIDTH +: REG_WIDTH];
                    end
                end
            end
            // Zero register wins over both storage and bypass.
            if ((ZERO_REG != 0) && (rf.rd_addr_i[p*AW +: AW] == '0)) begin
                rd_next[p*LW +: LW] = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int p = 0; p < READ_PORTS; p++) begin
                rd_valid_q[p] <= ready_q && rf.rd_en_i[p];
                // Data holds when the port is idle so consumers may re-sample it.
                if (ready_q && rf.rd_en_i[p]) begin
                    rd_data_q[p*LW +: LW] <= rd_next[p*LW +: LW];
                end
            end
        end
    end

    assign rf.ready_o    = ready_q;
    assign rf.rd_data_o  = rd_data_q;
    assign rf.rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_vector_register_file.sv
// Bench for vector_register_file: two instances (bypass+zero-reg, and neither)
// driven with identical stimulus, checked against an array-based reference model.
// Directed steps first, then a randomized phase with occasional resets.
module tb_vector_register_file;
    localparam int RC = 32;
    localparam int RW = 32;
    localparam int LC = 4;
    localparam int RP = 2;
    localparam int AW = 5;
    localparam int LW = LC * RW;

    logic           clk = 1'b0;
    logic           reset;
    logic [RP-1:0]  rd_en;
    logic [RP*AW-1:0] rd_addr;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [LC-1:0]  wr_mask;
    logic [LW-1:0]  wr_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vector_register_file_if #(.REG_COUNT(RC), .REG_WIDTH(RW), .LANE_COUNT(LC), .READ_PORTS(RP)) ifa ();
    vector_register_file_if #(.REG_COUNT(RC), .REG_WIDTH(RW), .LANE_COUNT(LC), .READ_PORTS(RP)) ifb ();

    assign ifa.rd_en_i = rd_en;        assign ifb.rd_en_i = rd_en;
    assign ifa.rd_addr_i = rd_addr;    assign ifb.rd_addr_i = rd_addr;
    assign ifa.wr_en_i = wr_en;        assign ifb.wr_en_i = wr_en;
    assign ifa.wr_addr_i = wr_addr;    assign ifb.wr_addr_i = wr_addr;
    assign ifa.wr_lane_mask_i = wr_mask; assign ifb.wr_lane_mask_i = wr_mask;
    assign ifa.wr_data_i = wr_data;    assign ifb.wr_data_i = wr_data;

    vector_register_file #(.REG_COUNT(RC), .REG_WIDTH(RW), .LANE_COUNT(LC), .READ_PORTS(RP),
                           .ZERO_REG(1), .BYPASS(1)) u_a (.clk_i(clk), .reset_i(reset), .rf(ifa));
    vector_register_file #(.REG_COUNT(RC), .REG_WIDTH(RW), .LANE_COUNT(LC), .READ_PORTS(RP),
                           .ZERO_REG(0), .BYPASS(0)) u_b (.clk_i(clk), .reset_i(reset), .rf(ifb));

    // Reference model: index 0 = instance a (bypass, zero reg), 1 = instance b.
    bit             bypass_of [2] = '{1'b1, 1'b0};
    bit             zero_of   [2] = '{1'b1, 1'b0};
    logic [LW-1:0]  m         [2][RC];
    logic [RP*LW-1:0] exp_data [2];
    logic [RP-1:0]  exp_valid [2];
    int             edges = 0;

    task automatic check(input string tag, input logic [RP*LW-1:0] obs, input logic [RP*LW-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [LW-1:0] merge(input logic [LW-1:0] old_v, input logic [LW-1:0] new_v,
                                            input logic [LC-1:0] mask);
        logic [LW-1:0] r;
        r = old_v;
        for (int k = 0; k < LC; k++)
            if (mask[k]) r[k*RW +: RW] = new_v[k*RW +: RW];
        return r;
    endfunction

    // Advance one clock: predict from the model, clock the DUTs, compare.
    task automatic step();
        bit rdy;
        bit wr_live;
        int a;
        logic [LW-1:0] v;
        rdy = (edges >= RC);
        if (reset) begin
            edges = 0;
            for (int i = 0; i < 2; i++) begin
                for (int r = 0; r < RC; r++) m[i][r] = '0;
                exp_data[i]  = '0;
                exp_valid[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_live = rdy && wr_en && !(zero_of[i] && wr_addr == 0);
                for (int p = 0; p < RP; p++) begin
                    if (rdy && rd_en[p]) begin
                        a = int'(rd_addr[p*AW +: AW]);
                        v = m[i][a];
                        if (bypass_of[i] && wr_live && int'(wr_addr) == a) v = merge(v, wr_data, wr_mask);
                        if (zero_of[i] && a == 0) v = '0;
                        exp_data[i][p*LW +: LW] = v;
                        exp_valid[i][p] = 1'b1;
                    end else begin
                        exp_valid[i][p] = 1'b0;
                    end
                end
                if (wr_live) m[i][wr_addr] = merge(m[i][wr_addr], wr_data, wr_mask);
            end
            if (edges < RC) edges++;
        end
        @(posedge clk);
        #1;
        check("ready_a", (RP*LW)'(ifa.ready_o), (RP*LW)'(edges >= RC));
        check("ready_b", (RP*LW)'(ifb.ready_o), (RP*LW)'(edges >= RC));
        check("valid_a", (RP*LW)'(ifa.rd_valid_o), (RP*LW)'(exp_valid[0]));
        check("valid_b", (RP*LW)'(ifb.rd_valid_o), (RP*LW)'(exp_valid[1]));
        check("data_a", ifa.rd_data_o, exp_data[0]);
        check("data_b", ifb.rd_data_o, exp_data[1]);
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    endtask

    initial begin
        logic [LW-1:0] k_init;
        logic [LW-1:0] k_mix;
        logic [LW-1:0] k_dead;
        k_init = {32'h44, 32'h33, 32'h22, 32'h11};
        k_mix  = {32'h44, 32'hFF, 32'h22, 32'hFF};
        k_dead = {4{32'hDEADBEEF}};

        // Reset.
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Clear sweep: requests issued but ignored; ready rises after exactly RC edges.
        for (int i = 0; i < RC; i++) begin
            rd_en = 2'b11;
            rd_addr = {AW'($urandom_range(0, RC-1)), AW'($urandom_range(0, RC-1))};
            wr_en = 1'b1; wr_addr = 5'd9; wr_mask = 4'hF; wr_data = {4{$urandom}};
            step();
            check("clear_ready", (RP*LW)'(ifa.ready_o), (RP*LW)'(i == RC-1));
            check("clear_nvalid", (RP*LW)'(ifa.rd_valid_o), '0);
        end

        // First read after the sweep: r5 on both ports is zero.
        idle(); rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        step();
        check("r5_zero", ifa.rd_data_o, '0);

        // Full write of r3, then read on port 1.
        idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_mask = 4'hF; wr_data = k_init;
        step();
        idle(); rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
        step();
        check("r3_valid", (RP*LW)'(ifa.rd_valid_o), (RP*LW)'(2'b10));
        check("r3_port1", (RP*LW)'(ifa.rd_data_o[LW +: LW]), (RP*LW)'(k_init));

        // Partial write colliding with a port-0 read of r3.
        idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_mask = 4'b0101; wr_data = {4{32'hFF}};
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step();
        check("coll_bypass", (RP*LW)'(ifa.rd_data_o[0 +: LW]), (RP*LW)'(k_mix));
        check("coll_nobypass", (RP*LW)'(ifb.rd_data_o[0 +: LW]), (RP*LW)'(k_init));
        idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step();
        check("coll_after_b", (RP*LW)'(ifb.rd_data_o[0 +: LW]), (RP*LW)'(k_mix));

        // Zero register: write r0 while reading it, then read again.
        idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_mask = 4'hF; wr_data = k_dead;
        rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        step();
        check("r0_same_a", ifa.rd_data_o, '0);
        idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        step();
        check("r0_next_a", ifa.rd_data_o, '0);
        check("r0_next_b", ifb.rd_data_o, {k_dead, k_dead});

        // Read r3 once, then idle the read ports for 5 cycles while writing r3.
        idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step();
        for (int i = 0; i < 5; i++) begin
            idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_mask = 4'hF; wr_data = {4{$urandom}};
            rd_addr = {5'd3, 5'd3};
            step();
            check("hold_nvalid", (RP*LW)'(ifa.rd_valid_o), '0);
            check("hold_data", (RP*LW)'(ifa.rd_data_o[0 +: LW]), (RP*LW)'(k_mix));
        end

        // Reset pulse mid-sweep: r7 written earlier must be cleared.
        idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_mask = 4'hF; wr_data = {4{$urandom | 32'h1}};
        step();
        idle(); reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_ready_low", (RP*LW)'(ifa.ready_o), '0);
        for (int i = 0; i < RC; i++) begin
            step();
            check("resweep_ready", (RP*LW)'(ifb.ready_o), (RP*LW)'(i == RC-1));
        end
        rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
        step();
        check("r7_cleared", ifb.rd_data_o, '0);

        // Randomized traffic on a small address window to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 149) == 0);
            rd_en   = RP'($urandom_range(0, 3));
            rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_addr = AW'($urandom_range(0, 7));
            wr_mask = LC'($urandom_range(0, 15));
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vector_register_file.md
Name: vector_register_file

Overview:
- Parametrised lane-parallel register file for the GPU core. Each register holds one REG_WIDTH word per SIMD lane.
- Multiple read ports, one per-lane-masked write port, 1-cycle registered reads, optional write-to-read bypass, optional hardwired zero register.
- Post-reset clear sweep, so storage can map to block RAM instead of a flop-reset array.
- All logic on the rising edge of clk_i.

Parameters:
- REG_COUNT, 32: registers per lane; power of two, >= 2.
- REG_WIDTH, 32: bits per lane word.
- LANE_COUNT, 4: SIMD lanes per register.
- READ_PORTS, 2: independent read ports, >= 1.
- ZERO_REG, 1: 1 = register 0 always reads 0 and writes to it are dropped.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching reads.

Ports:
(AW = $clog2(REG_COUNT); LW = LANE_COUNT*REG_WIDTH; lane k occupies bits [k*REG_WIDTH +: REG_WIDTH]; port p occupies slice p.)
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- ready_o  output  1  high when clear sweep is done and ports are accepted.
- rd_en_i  input  READ_PORTS  per-port read request.
- rd_addr_i  input  READ_PORTS*AW  per-port read address.
- rd_data_o  output  READ_PORTS*LW  per-port registered read data.
- rd_valid_o  output  READ_PORTS  per-port: rd_data_o updated this cycle.
- wr_en_i  input  1  write request.
- wr_addr_i  input  AW  write address.
- wr_lane_mask_i  input  LANE_COUNT  per-lane write enable.
- wr_data_i  input  LW  write data.

Behaviour:
- Reset and clear (synchronous, active-high, decided):
  - Any edge with reset_i=1: state CLEAR, clear_cnt=0, ready_o=0, rd_valid_o=0, rd_data_o=0.
  - Reset asserted mid-sweep or in READY restarts the sweep from 0.
- State CLEAR, each edge with reset_i=0:
  - Write 0 to all lanes of register clear_cnt; increment clear_cnt.
  - At clear_cnt==REG_COUNT-1: write it, then go to READY.
  - ready_o reads 1 after exactly REG_COUNT non-reset edges.
  - rd_en_i and wr_en_i are ignored; rd_valid_o stays 0.
- State READY: stays here until reset.
- Write:
  - Edge with ready_o=1 and wr_en_i=1: lane k of register wr_addr_i takes wr_data_i lane k where wr_lane_mask_i[k]=1.
  - Unmasked lanes keep their value.
  - A mask of all zeros is a no-op.
  - ZERO_REG=1 and wr_addr_i=0: write dropped.
- Read (latency 1):
  - Edge with ready_o=1 and rd_en_i[p]=1: rd_data_o[p] takes the contents of rd_addr_i[p]; rd_valid_o[p]=1 for the following cycle.
  - rd_en_i[p]=0: rd_valid_o[p]=0 and rd_data_o[p] holds its previous value.
  - All ports independent; the same address on several ports is legal.
- Read/write collision (same edge, rd_addr==wr_addr, wr_en=1, address not the dropped zero register):
  - BYPASS=1: masked lanes return the new wr_data_i, unmasked lanes return the old value.
  - BYPASS=0: all lanes return the old value; the new value is visible on reads from the next edge.
- ZERO_REG=1: reads of address 0 return all zeros regardless of storage or bypass.
- No undefined outputs after reset. The storage array needs no reset, since the clear sweep covers it.

Test Plan:
- Reset, then hold reset_i=0 with default params -> ready_o=0 for 32 edges and 1 after the 32nd. Reads during CLEAR give rd_valid_o=0. First READY read of r5 on all lanes = 0.
- Write r3 with mask 4'b1111, data lanes {0x44,0x33,0x22,0x11}; read r3 on port 1 next cycle -> rd_valid_o=2'b10 one cycle later, rd_data_o[1]={0x44,0x33,0x22,0x11}.
- Write r3 mask 4'b0101 data all 0xFF while port 0 reads r3 on the same edge:
  - BYPASS=1 -> {0x44,0xFF,0x22,0xFF}.
  - BYPASS=0 -> {0x44,0x33,0x22,0x11}; the next read returns {0x44,0xFF,0x22,0xFF}.
- ZERO_REG=1: write r0 with 0xDEADBEEF on all lanes; read r0 on both ports the same and the next cycle -> all zeros. With ZERO_REG=0 the next-cycle read returns 0xDEADBEEF.
- Pulse reset_i for 1 cycle at clear_cnt=10, after r7 was written in a previous READY period -> ready_o drops, sweep restarts, ready_o returns after 32 edges, r7 reads 0.
- Read r3 once, then hold rd_en_i=0 for 5 cycles while writing r3 -> rd_valid_o=0 and rd_data_o unchanged throughout.
